// File: rtl/rr_arb4_mux_pkg.sv
// ----------------------------------------------------------------------------
// rr_arb4_mux_pkg
// Shared definitions for the four-requester round-robin arbiter/mux:
//   - NREQ / SELW       : number of requesters and width of their index
//   - arb_state_t       : arbiter FSM encoding (IDLE=0, BUSY=1)
//   - onehot4()         : index -> one-hot grant vector
//   - rr_pick()         : round-robin winner search starting at a pointer
// ----------------------------------------------------------------------------
package rr_arb4_mux_pkg;

    localparam int NREQ = 4;
    localparam int SELW = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Expand a requester index into its one-hot grant vector.
    function automatic logic [NREQ-1:0] onehot4(input logic [SELW-1:0] idx);
        logic [NREQ-1:0] vec_s;
        vec_s      = 4'b0000;
        vec_s[idx] = 1'b1;
        return vec_s;
    endfunction

    // First requester found scanning ptr, ptr+1, ... (mod 4). When nothing is
    // requesting the result is ptr; callers only use it when |req is true.
    function automatic logic [SELW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                input logic [SELW-1:0] ptr);
        logic [SELW-1:0] idx_s;
        logic [SELW-1:0] win_s;
        logic            found_s;
        win_s   = ptr;
        found_s = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            // Two-bit addition wraps 3 -> 0 by construction.
            idx_s = ptr + SELW'(k);
            if (!found_s && req[idx_s]) begin
                win_s   = idx_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        return win_s;
    endfunction

endpackage

// File: rtl/rr_arb4_mux_mux4_dw.sv
// ----------------------------------------------------------------------------
// mux4_dw
// Pure combinational 4:1 data multiplexer.
//   sel  in  2   source index
//   d0..d3 in DW source data
//   y    out DW  selected data
// ----------------------------------------------------------------------------
module mux4_dw #(
    parameter int DW = 8
) (
    input  logic [1:0]    sel,
    input  logic [DW-1:0] d0,
    input  logic [DW-1:0] d1,
    input  logic [DW-1:0] d2,
    input  logic [DW-1:0] d3,
    output logic [DW-1:0] y
);

    // Data select; the default arm is unreachable for a 2-bit select.
    always_comb begin
        y = d0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/rr_arb4_mux.sv
// ----------------------------------------------------------------------------
// rr_arb4_mux
// Round-robin arbiter with burst control sharing one DW-bit 4:1 datapath among
// four requesters. The granted source streams to a single valid/ready output.
//   clk        in   1    rising-edge clock
//   rst_n      in   1    synchronous reset, active-low
//   req        in   4    per-source request, held until its grant ends
//   din0..din3 in   DW   source data
//   out_ready  in   1    sink accepts dout this cycle
//   gnt        out  4    registered one-hot grant, zero while idle
//   sel        out  2    registered mux select (holds while idle)
//   out_valid  out  1    dout valid (granted source still requesting)
//   dout       out  DW   din[sel]
// MAX_BURST bounds the beats per grant; 0 means the grant lasts until the
// source drops its request.
// ----------------------------------------------------------------------------
module rr_arb4_mux
    import rr_arb4_mux_pkg::*;
#(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      req,
    input  logic [DW-1:0]   din0,
    input  logic [DW-1:0]   din1,
    input  logic [DW-1:0]   din2,
    input  logic [DW-1:0]   din3,
    input  logic            out_ready,
    output logic [3:0]      gnt,
    output logic [1:0]      sel,
    output logic            out_valid,
    output logic [DW-1:0]   dout
);

    localparam int            CW            = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
    localparam bit            BURST_LIMITED = (MAX_BURST != 0);
    localparam logic [CW-1:0] CNT_LAST      = BURST_LIMITED ? CW'(MAX_BURST - 1) : {CW{1'b0}};
    localparam logic [CW-1:0] CNT_SAT       = {CW{1'b1}};

    arb_state_t    state_r, state_s;
    logic [3:0]    gnt_r,   gnt_s;
    logic [1:0]    sel_r,   sel_s;
    logic [1:0]    ptr_r,   ptr_s;
    logic [CW-1:0] cnt_r,   cnt_s;

    logic          out_valid_s;
    logic          xfer_s;
    logic          last_beat_s;
    logic [1:0]    win_s;

    // Handshake qualifiers derived from the current grant.
    always_comb begin
        out_valid_s = (state_r == ST_BUSY) && req[sel_r];
        xfer_s      = out_valid_s && out_ready;
        last_beat_s = BURST_LIMITED && (cnt_r == CNT_LAST);
        win_s       = rr_pick(req, ptr_r);
    end

    // Next-state logic: arbitrate in IDLE, count beats and release in BUSY.
    always_comb begin
        state_s = state_r;
        gnt_s   = gnt_r;
        sel_s   = sel_r;
        ptr_s   = ptr_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    gnt_s   = onehot4(win_s);
                    sel_s   = win_s;
                    cnt_s   = {CW{1'b0}};
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Release on request drop, or on the final beat of a bounded
                // burst; the pointer moves past the source just served.
                if (!req[sel_r] || (xfer_s && last_beat_s)) begin
                    gnt_s   = 4'b0000;
                    ptr_s   = sel_r + 2'd1;
                    cnt_s   = {CW{1'b0}};
                    state_s = ST_IDLE;
                end else if (xfer_s) begin
                    // Saturation only matters for unlimited bursts.
                    if (cnt_r != CNT_SAT) begin
                        cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_s = cnt_r;
                    end
                end else begin
                    state_s = ST_BUSY;
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = 4'b0000;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            gnt_r   <= 4'b0000;
            sel_r   <= 2'd0;
            ptr_r   <= 2'd0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_s;
            gnt_r   <= gnt_s;
            sel_r   <= sel_s;
            ptr_r   <= ptr_s;
            cnt_r   <= cnt_s;
        end
    end

    mux4_dw #(
        .DW (DW)
    ) u_mux (
        .sel (sel_r),
        .d0  (din0),
        .d1  (din1),
        .d2  (din2),
        .d3  (din3),
        .y   (dout)
    );

    assign gnt       = gnt_r;
    assign sel       = sel_r;
    assign out_valid = out_valid_s;

endmodule

// File: tb/tb_rr_arb4_mux.sv
// ----------------------------------------------------------------------------
// tb_rr_arb4_mux
// Directed bench for rr_arb4_mux (DW=8, MAX_BURST=4). Inputs are driven on the
// falling edge; outputs are sampled 1 ns later, i.e. each row's expectation is
// what the design shows in that cycle, before the rising edge consumes it.
// ----------------------------------------------------------------------------
module tb_rr_arb4_mux;

    localparam logic [7:0] D0 = 8'h10;
    localparam logic [7:0] D1 = 8'h21;
    localparam logic [7:0] D2 = 8'hA5;
    localparam logic [7:0] D3 = 8'h3C;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       rdy;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       vld;
        logic [7:0] dout;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] din0, din1, din2, din3;
    logic       out_ready;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       out_valid;
    logic [7:0] dout;

    int   n_cmp;
    int   n_bad;
    int   step_no;
    vec_t tbl[$];

    rr_arb4_mux #(
        .DW        (8),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .din0      (din0),
        .din1      (din1),
        .din2      (din2),
        .din3      (din3),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .dout      (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got step %0d want completion", step_no);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h want %h", nm, step_no, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic rdy,
                        input logic [3:0] eg, input logic [1:0] es,
                        input logic ev, input logic [7:0] ed);
        @(negedge clk);
        rst_n     = r;
        req       = rq;
        out_ready = rdy;
        #1;
        check("gnt",       {4'h0, gnt},       {4'h0, eg});
        check("sel",       {6'h00, sel},      {6'h00, es});
        check("out_valid", {7'h00, out_valid}, {7'h00, ev});
        check("dout",      dout,              ed);
        step_no++;
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic rdy,
                       input logic [3:0] eg, input logic [1:0] es,
                       input logic ev, input logic [7:0] ed);
        vec_t v;
        v.rst_n = r;  v.req = rq;  v.rdy = rdy;
        v.gnt   = eg; v.sel = es;  v.vld = ev; v.dout = ed;
        tbl.push_back(v);
    endtask

    initial begin
        logic [7:0] dtab [4];
        logic [7:0] e1;
        logic [1:0] prev;
        dtab = '{D0, D1, D2, D3};
        n_cmp = 0; n_bad = 0; step_no = 0;
        rst_n = 1'b0; req = 4'hF; out_ready = 1'b1;
        din0 = D0; din1 = D1; din2 = D2; din3 = D3;
        @(posedge clk);

        // Reset held with every source requesting.
        for (int i = 0; i < 3; i++) add(1'b0, 4'hF, 1'b1, 4'h0, 2'd0, 1'b0, D0);

        // Lone requester 2: one-cycle latency, 4 beats, idle cycle, re-grant.
        add(1'b1, 4'h4, 1'b1, 4'h0, 2'd0, 1'b0, D0);
        for (int i = 0; i < 4; i++) add(1'b1, 4'h4, 1'b1, 4'h4, 2'd2, 1'b1, D2);
        add(1'b1, 4'h4, 1'b1, 4'h0, 2'd2, 1'b0, D2);
        add(1'b1, 4'h4, 1'b1, 4'h4, 2'd2, 1'b1, D2);
        add(1'b1, 4'h0, 1'b1, 4'h4, 2'd2, 1'b0, D2);

        // All requesting after reset: 0,1,2,3,0, four beats each, idle between.
        add(1'b0, 4'hF, 1'b1, 4'h0, 2'd2, 1'b0, D2);
        prev = 2'd0;
        for (int s = 0; s < 4; s++) begin
            add(1'b1, 4'hF, 1'b1, 4'h0, prev, 1'b0, dtab[prev]);
            for (int b = 0; b < 4; b++)
                add(1'b1, 4'hF, 1'b1, 4'b0001 << s, 2'(s), 1'b1, dtab[s]);
            prev = 2'(s);
        end
        add(1'b1, 4'hF, 1'b1, 4'h0, 2'd3, 1'b0, D3);
        add(1'b1, 4'hF, 1'b1, 4'h1, 2'd0, 1'b1, D0);
        add(1'b0, 4'h0, 1'b1, 4'h1, 2'd0, 1'b0, D0);

        foreach (tbl[i])
            step(tbl[i].rst_n, tbl[i].req, tbl[i].rdy,
                 tbl[i].gnt, tbl[i].sel, tbl[i].vld, tbl[i].dout);

        // Backpressure on source 1: grant held, no beats counted, dout tracks din1.
        step(1'b1, 4'h2, 1'b0, 4'h0, 2'd0, 1'b0, D0);
        for (int i = 0; i < 5; i++) begin
            e1   = 8'h40 + 8'(i);
            din1 = e1;
            step(1'b1, 4'h2, 1'b0, 4'h2, 2'd1, 1'b1, e1);
        end
        din1 = D1;
        for (int i = 0; i < 4; i++) step(1'b1, 4'h2, 1'b1, 4'h2, 2'd1, 1'b1, D1);
        step(1'b1, 4'h0, 1'b1, 4'h0, 2'd1, 1'b0, D1);

        // Source 3 drops after 2 beats; pointer wraps so source 0 wins next.
        step(1'b1, 4'h9, 1'b1, 4'h0, 2'd1, 1'b0, D1);
        step(1'b1, 4'h9, 1'b1, 4'h8, 2'd3, 1'b1, D3);
        step(1'b1, 4'h9, 1'b1, 4'h8, 2'd3, 1'b1, D3);
        step(1'b1, 4'h1, 1'b1, 4'h8, 2'd3, 1'b0, D3);
        step(1'b1, 4'h9, 1'b1, 4'h0, 2'd3, 1'b0, D3);
        step(1'b1, 4'h9, 1'b1, 4'h1, 2'd0, 1'b1, D0);
        step(1'b1, 4'h0, 1'b1, 4'h1, 2'd0, 1'b0, D0);

        // Move the pointer to 3, then reset mid-burst; afterwards 1010 -> src1.
        step(1'b1, 4'h4, 1'b1, 4'h0, 2'd0, 1'b0, D0);
        step(1'b1, 4'h0, 1'b1, 4'h4, 2'd2, 1'b0, D2);
        step(1'b1, 4'h1, 1'b1, 4'h0, 2'd2, 1'b0, D2);
        step(1'b1, 4'h1, 1'b1, 4'h1, 2'd0, 1'b1, D0);
        step(1'b1, 4'h1, 1'b1, 4'h1, 2'd0, 1'b1, D0);
        step(1'b0, 4'h1, 1'b1, 4'h1, 2'd0, 1'b1, D0);
        step(1'b1, 4'hA, 1'b1, 4'h0, 2'd0, 1'b0, D0);
        for (int i = 0; i < 4; i++) step(1'b1, 4'hA, 1'b1, 4'h2, 2'd1, 1'b1, D1);
        step(1'b1, 4'hA, 1'b1, 4'h0, 2'd1, 1'b0, D1);
        step(1'b1, 4'hA, 1'b1, 4'h8, 2'd3, 1'b1, D3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
